// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the seven-segment display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam int AN_W  = 4;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] c_glyph_0 = 7'h40;
    localparam logic [SEG_W-1:0] c_glyph_1 = 7'h79;
    localparam logic [SEG_W-1:0] c_glyph_2 = 7'h24;
    localparam logic [SEG_W-1:0] c_glyph_3 = 7'h30;
    localparam logic [SEG_W-1:0] c_glyph_4 = 7'h19;
    localparam logic [SEG_W-1:0] c_glyph_5 = 7'h12;
    localparam logic [SEG_W-1:0] c_glyph_6 = 7'h02;
    localparam logic [SEG_W-1:0] c_glyph_7 = 7'h78;
    localparam logic [SEG_W-1:0] c_glyph_8 = 7'h00;
    localparam logic [SEG_W-1:0] c_glyph_9 = 7'h10;
    localparam logic [SEG_W-1:0] c_glyph_a = 7'h08;
    localparam logic [SEG_W-1:0] c_glyph_b = 7'h03;
    localparam logic [SEG_W-1:0] c_glyph_c = 7'h46;
    localparam logic [SEG_W-1:0] c_glyph_d = 7'h21;
    localparam logic [SEG_W-1:0] c_glyph_e = 7'h06;
    localparam logic [SEG_W-1:0] c_glyph_f = 7'h0E;
    localparam logic [SEG_W-1:0] c_seg_blank = 7'h7F;

    localparam logic [AN_W-1:0] c_an_blank = 4'b1111;
    localparam logic [AN_W-1:0] c_an_d0    = 4'b1110;
    localparam logic [AN_W-1:0] c_an_d1    = 4'b1101;
    localparam logic [AN_W-1:0] c_an_d2    = 4'b1011;
    localparam logic [AN_W-1:0] c_an_d3    = 4'b0111;

    typedef enum logic [0:0] {
        ST_WAIT_D0 = 1'b0,
        ST_COLLECT = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } glyph_dec_t;

    // Forward mapping, shared with the display driver side.
    function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] nibble);
        logic [SEG_W-1:0] seg;
        case (nibble)
            4'h0:    seg = c_glyph_0;
            4'h1:    seg = c_glyph_1;
            4'h2:    seg = c_glyph_2;
            4'h3:    seg = c_glyph_3;
            4'h4:    seg = c_glyph_4;
            4'h5:    seg = c_glyph_5;
            4'h6:    seg = c_glyph_6;
            4'h7:    seg = c_glyph_7;
            4'h8:    seg = c_glyph_8;
            4'h9:    seg = c_glyph_9;
            4'hA:    seg = c_glyph_a;
            4'hB:    seg = c_glyph_b;
            4'hC:    seg = c_glyph_c;
            4'hD:    seg = c_glyph_d;
            4'hE:    seg = c_glyph_e;
            default: seg = c_glyph_f;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_monitor_if
// Description : Display bus in, reassembled frame and error flags out.
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_seg_monitor_if;
    import seven_seg_pkg::*;

    logic [AN_W-1:0]  an_in;
    logic [SEG_W-1:0] seg_in;
    logic             clear_err;
    logic [15:0]      digits;
    logic             frame_done;
    logic             pattern_err;
    logic             anode_err;
    logic             order_err;

    modport master (
        output an_in,
        output seg_in,
        output clear_err,
        input  digits,
        input  frame_done,
        input  pattern_err,
        input  anode_err,
        input  order_err
    );

    modport slave (
        input  an_in,
        input  seg_in,
        input  clear_err,
        output digits,
        output frame_done,
        output pattern_err,
        output anode_err,
        output order_err
    );

endinterface
`default_nettype wire

// File: rtl/seg_glyph_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_glyph_decoder
// Description : Active-low segment pattern to hex nibble, with match flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_glyph_decoder
    import seven_seg_pkg::*;
(
    input  wire logic [SEG_W-1:0] i_seg,
    output logic                  o_valid,
    output logic [3:0]            o_nibble
);

    glyph_dec_t w_dec;

    always_comb begin
        w_dec = '{valid: 1'b1, nibble: 4'h0};
        case (i_seg)
            c_glyph_0: w_dec.nibble = 4'h0;
            c_glyph_1: w_dec.nibble = 4'h1;
            c_glyph_2: w_dec.nibble = 4'h2;
            c_glyph_3: w_dec.nibble = 4'h3;
            c_glyph_4: w_dec.nibble = 4'h4;
            c_glyph_5: w_dec.nibble = 4'h5;
            c_glyph_6: w_dec.nibble = 4'h6;
            c_glyph_7: w_dec.nibble = 4'h7;
            c_glyph_8: w_dec.nibble = 4'h8;
            c_glyph_9: w_dec.nibble = 4'h9;
            c_glyph_a: w_dec.nibble = 4'hA;
            c_glyph_b: w_dec.nibble = 4'hB;
            c_glyph_c: w_dec.nibble = 4'hC;
            c_glyph_d: w_dec.nibble = 4'hD;
            c_glyph_e: w_dec.nibble = 4'hE;
            c_glyph_f: w_dec.nibble = 4'hF;
            default:   w_dec.valid  = 1'b0;
        endcase
    end

    assign o_valid  = w_dec.valid;
    assign o_nibble = w_dec.nibble;

endmodule
`default_nettype wire

// File: rtl/seven_seg_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_monitor
// Description : Samples the multiplexed display bus, deglitches it and
//               rebuilds complete 4-digit frames with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_monitor
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seven_seg_monitor_if.slave bus
);

    localparam int          SAMPLE_W      = AN_W + SEG_W;
    localparam logic [7:0]  c_settle_last = 8'(SETTLE_CYCLES - 1);

    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] r_prev;
    logic [7:0]          r_stable_cnt;

    // r_stable_cnt==k means the last k+1 samples (ending at r_prev) agree,
    // so r_prev is always the settled value when the strobe fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample     <= '1;
            r_prev       <= '1;
            r_stable_cnt <= 8'd0;
        end else begin
            r_sample <= {bus.an_in, bus.seg_in};
            r_prev   <= r_sample;
            if (r_sample != r_prev) begin
                r_stable_cnt <= 8'd0;
            end else if (r_stable_cnt != 8'hFF) begin
                r_stable_cnt <= r_stable_cnt + 8'd1;
            end
        end
    end

    logic             w_capture;
    logic [AN_W-1:0]  w_cap_an;
    logic [SEG_W-1:0] w_cap_seg;
    logic             w_an_blank;
    logic             w_an_onehot;
    logic [1:0]       w_index;
    logic             w_glyph_valid;
    logic [3:0]       w_glyph_nibble;

    assign w_capture = (r_stable_cnt == c_settle_last);
    assign w_cap_an  = r_prev[SAMPLE_W-1 -: AN_W];
    assign w_cap_seg = r_prev[SEG_W-1:0];

    always_comb begin
        w_an_blank  = 1'b0;
        w_an_onehot = 1'b1;
        w_index     = 2'd0;
        case (w_cap_an)
            c_an_d0:    w_index = 2'd0;
            c_an_d1:    w_index = 2'd1;
            c_an_d2:    w_index = 2'd2;
            c_an_d3:    w_index = 2'd3;
            c_an_blank: begin
                w_an_blank  = 1'b1;
                w_an_onehot = 1'b0;
            end
            default:    w_an_onehot = 1'b0;
        endcase
    end

    seg_glyph_decoder u_decoder (
        .i_seg    (w_cap_seg),
        .o_valid  (w_glyph_valid),
        .o_nibble (w_glyph_nibble)
    );

    logic w_digit_evt;
    logic w_pattern_evt;
    logic w_anode_evt;

    assign w_digit_evt   = w_capture & w_an_onehot &  w_glyph_valid;
    assign w_pattern_evt = w_capture & w_an_onehot & ~w_glyph_valid;
    assign w_anode_evt   = w_capture & ~w_an_blank & ~w_an_onehot;

    frame_state_t r_state, w_state_nxt;
    logic [1:0]   r_expected, w_expected_nxt;
    logic [15:0]  r_shadow, w_shadow_nxt;
    logic [15:0]  r_digits, w_digits_nxt;
    logic         r_frame_done, w_frame_done_nxt;
    logic         w_order_evt;
    logic         r_pattern_err;
    logic         r_anode_err;
    logic         r_order_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_WAIT_D0;
            r_expected    <= 2'd0;
            r_shadow      <= 16'h0000;
            r_digits      <= 16'h0000;
            r_frame_done  <= 1'b0;
            r_pattern_err <= 1'b0;
            r_anode_err   <= 1'b0;
            r_order_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_expected    <= w_expected_nxt;
            r_shadow      <= w_shadow_nxt;
            r_digits      <= w_digits_nxt;
            r_frame_done  <= w_frame_done_nxt;
            // A new error event outranks a simultaneous clear
            r_pattern_err <= w_pattern_evt | (r_pattern_err & ~bus.clear_err);
            r_anode_err   <= w_anode_evt   | (r_anode_err   & ~bus.clear_err);
            r_order_err   <= w_order_evt   | (r_order_err   & ~bus.clear_err);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_expected_nxt   = r_expected;
        w_shadow_nxt     = r_shadow;
        w_digits_nxt     = r_digits;
        w_frame_done_nxt = 1'b0;
        w_order_evt      = 1'b0;

        if (w_pattern_evt) begin
            w_state_nxt = ST_WAIT_D0;
        end else if (w_digit_evt) begin
            case (r_state)
                ST_WAIT_D0: begin
                    if (w_index == 2'd0) begin
                        w_shadow_nxt[3:0] = w_glyph_nibble;
                        w_expected_nxt    = 2'd1;
                        w_state_nxt       = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_index == r_expected) begin
                        w_shadow_nxt[{w_index, 2'b00} +: 4] = w_glyph_nibble;
                        if (w_index == 2'd3) begin
                            w_digits_nxt     = {w_glyph_nibble, r_shadow[11:0]};
                            w_frame_done_nxt = 1'b1;
                            w_expected_nxt   = 2'd0;
                            w_state_nxt      = ST_WAIT_D0;
                        end else begin
                            w_expected_nxt = r_expected + 2'd1;
                        end
                    end else begin
                        w_order_evt = 1'b1;
                        if (w_index == 2'd0) begin
                            w_shadow_nxt[3:0] = w_glyph_nibble;
                            w_expected_nxt    = 2'd1;
                        end else begin
                            w_state_nxt = ST_WAIT_D0;
                        end
                    end
                end
                default: w_state_nxt = ST_WAIT_D0;
            endcase
        end
    end

    assign bus.digits      = r_digits;
    assign bus.frame_done  = r_frame_done;
    assign bus.pattern_err = r_pattern_err;
    assign bus.anode_err   = r_anode_err;
    assign bus.order_err   = r_order_err;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_monitor
// Description : Directed vector bench for seven_seg_monitor (SETTLE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_monitor;

    localparam int K_DRIVE = 0;
    localparam int K_RESET = 1;
    localparam int K_CHECK = 2;
    localparam int K_CLEAR = 3;

    typedef struct {
        int          kind;
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] exp_digits;
        int          exp_frames;
        logic [2:0]  exp_err;      // {order, anode, pattern}
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seven_seg_monitor_if bus();

    seven_seg_monitor #(.SETTLE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_frames = 0;
    int          n_bad_update = 0;
    int          frame_base = 0;
    logic [15:0] last_digits = 16'h0000;
    vec_t        vecs[$];

    // Count frame pulses and catch digits moving without frame_done
    always @(posedge clk) begin
        #1;
        if (bus.frame_done === 1'b1) n_frames++;
        if (reset !== 1'b1 && bus.digits !== last_digits && bus.frame_done !== 1'b1)
            n_bad_update++;
        last_digits = bus.digits;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int hold);
        bus.an_in  = an;
        bus.seg_in = seg;
        repeat (hold) @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.an_in     = 4'b1111;
        bus.seg_in    = 7'h7F;
        bus.clear_err = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        frame_base = n_frames;
        repeat (8) @(negedge clk);
    endtask

    function automatic vec_t mk(input int kind, input logic [3:0] an, input logic [6:0] seg,
                                input int hold, input logic [15:0] dg, input int fr,
                                input logic [2:0] er, input string name);
        vec_t v;
        v.kind = kind; v.an = an; v.seg = seg; v.hold = hold;
        v.exp_digits = dg; v.exp_frames = fr; v.exp_err = er; v.name = name;
        return v;
    endfunction

    function automatic vec_t d(input logic [3:0] an, input logic [6:0] seg, input int hold);
        return mk(K_DRIVE, an, seg, hold, 16'h0, 0, 3'b000, "");
    endfunction

    function automatic vec_t chk(input string name, input logic [15:0] dg, input int fr,
                                 input logic [2:0] er);
        return mk(K_CHECK, 4'hF, 7'h7F, 0, dg, fr, er, name);
    endfunction

    function automatic vec_t rst();
        return mk(K_RESET, 4'hF, 7'h7F, 0, 16'h0, 0, 3'b000, "");
    endfunction

    initial begin
        int   lat;
        logic seen;

        reset         = 1'b1;
        bus.an_in     = 4'b1111;
        bus.seg_in    = 7'h7F;
        bus.clear_err = 1'b0;

        // Clean scan 1,2,3,4
        vecs.push_back(rst());
        vecs.push_back(chk("reset_state", 16'h0000, 0, 3'b000));
        vecs.push_back(d(4'b1110, 7'h79, 8));
        vecs.push_back(d(4'b1101, 7'h24, 8));
        vecs.push_back(d(4'b1011, 7'h30, 8));
        vecs.push_back(d(4'b0111, 7'h19, 8));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("scan_4321", 16'h4321, 1, 3'b000));
        // Held one sample short of settling
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h79, 3));
        vecs.push_back(d(4'b1101, 7'h24, 3));
        vecs.push_back(d(4'b1011, 7'h30, 3));
        vecs.push_back(d(4'b0111, 7'h19, 3));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("short_hold", 16'h0000, 0, 3'b000));
        // Held exactly SETTLE_CYCLES samples
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h79, 4));
        vecs.push_back(d(4'b1101, 7'h24, 4));
        vecs.push_back(d(4'b1011, 7'h30, 4));
        vecs.push_back(d(4'b0111, 7'h19, 4));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("exact_hold", 16'h4321, 1, 3'b000));
        // One-sample glitches between digits
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h79, 8));
        vecs.push_back(d(4'b1110, 7'h7F, 1));
        vecs.push_back(d(4'b1101, 7'h24, 8));
        vecs.push_back(d(4'b1101, 7'h7F, 1));
        vecs.push_back(d(4'b1011, 7'h30, 8));
        vecs.push_back(d(4'b0111, 7'h19, 8));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("glitch", 16'h4321, 1, 3'b000));
        // Out-of-order digit, then recovery with A,b,C,d
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h12, 8));
        vecs.push_back(d(4'b1011, 7'h02, 8));
        vecs.push_back(chk("order_err", 16'h0000, 0, 3'b100));
        vecs.push_back(d(4'b1110, 7'h08, 8));
        vecs.push_back(d(4'b1101, 7'h03, 8));
        vecs.push_back(d(4'b1011, 7'h46, 8));
        vecs.push_back(d(4'b0111, 7'h21, 8));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("order_recover", 16'hDCBA, 1, 3'b100));
        // Bad glyph, bad anode, clear
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h7F, 8));
        vecs.push_back(chk("pattern_err", 16'h0000, 0, 3'b001));
        vecs.push_back(d(4'b1100, 7'h40, 8));
        vecs.push_back(chk("anode_err", 16'h0000, 0, 3'b011));
        vecs.push_back(mk(K_CLEAR, 4'hF, 7'h7F, 0, 16'h0, 0, 3'b000, ""));
        vecs.push_back(chk("clear_err", 16'h0000, 0, 3'b000));
        // Reset mid-frame, then 3,0,1,2,3 with glyphs 7,8,9,A,b
        vecs.push_back(rst());
        vecs.push_back(d(4'b1110, 7'h79, 8));
        vecs.push_back(d(4'b1101, 7'h24, 8));
        vecs.push_back(d(4'b1011, 7'h30, 8));
        vecs.push_back(rst());
        vecs.push_back(chk("midframe_reset", 16'h0000, 0, 3'b000));
        vecs.push_back(d(4'b0111, 7'h78, 8));
        vecs.push_back(d(4'b1110, 7'h00, 8));
        vecs.push_back(d(4'b1101, 7'h10, 8));
        vecs.push_back(d(4'b1011, 7'h08, 8));
        vecs.push_back(d(4'b0111, 7'h03, 8));
        vecs.push_back(d(4'b1111, 7'h7F, 8));
        vecs.push_back(chk("after_reset", 16'hBA98, 1, 3'b000));

        @(negedge clk);
        foreach (vecs[i]) begin
            case (vecs[i].kind)
                K_DRIVE: drive(vecs[i].an, vecs[i].seg, vecs[i].hold);
                K_RESET: do_reset();
                K_CLEAR: begin
                    bus.clear_err = 1'b1;
                    @(negedge clk);
                    bus.clear_err = 1'b0;
                    @(negedge clk);
                end
                default: begin
                    check({vecs[i].name, "_digits"}, 32'(bus.digits), 32'(vecs[i].exp_digits));
                    check({vecs[i].name, "_frames"}, n_frames - frame_base, vecs[i].exp_frames);
                    check({vecs[i].name, "_errs"},
                          32'({bus.order_err, bus.anode_err, bus.pattern_err}),
                          32'(vecs[i].exp_err));
                end
            endcase
        end

        // Capture latency: last digit driven to frame_done is SETTLE_CYCLES+2 edges
        do_reset();
        drive(4'b1110, 7'h79, 8);
        drive(4'b1101, 7'h24, 8);
        drive(4'b1011, 7'h30, 8);
        bus.an_in  = 4'b0111;
        bus.seg_in = 7'h19;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        check("latency_edges", lat, 6);
        check("latency_digits", 32'(bus.digits), 32'h4321);
        @(negedge clk);
        check("frame_done_one_cycle", 32'(bus.frame_done), 32'd0);

        // Clear collides with a new anode error on the same edge
        drive(4'b1110, 7'h7F, 8);
        check("collide_pre", 32'({bus.anode_err, bus.pattern_err}), 32'b01);
        drive(4'b1100, 7'h40, 5);
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
        check("collide_post", 32'({bus.anode_err, bus.pattern_err}), 32'b10);

        repeat (4) @(negedge clk);
        check("no_partial_updates", n_bad_update, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_seg_monitor.md
# seven_seg_monitor

Receive-side counterpart of the display scanner. Samples the multiplexed anode/segment bus driving the 4-digit seven-segment display, filters switching glitches, decodes each stable segment pattern back to a hex nibble, and reassembles whole frames (digit 0→3). Used for loopback self-check of the display path on the board and as a bus monitor in testbenches.

## Interface
- SETTLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 2..255.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- an_in  in  4  anode strobes, active-low, one-hot when a digit is lit; 4'b1111 means blank.
- seg_in  in  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- clear_err  in  1  one-cycle pulse; clears all sticky error flags.
- digits  out  16  last complete frame, {d3,d2,d1,d0}, one nibble per digit.
- frame_done  out  1  one-cycle pulse when digits is updated.
- pattern_err  out  1  sticky: a settled seg_in matched no hex glyph.
- anode_err  out  1  sticky: a settled an_in was neither one-hot-low nor 4'b1111.
- order_err  out  1  sticky: a digit arrived out of 0,1,2,3 sequence.

## Operation
- Input stage: an_in/seg_in registered once into an 11-bit sample each cycle.
- Stability counter (8 bits, saturating): 0 when the current sample differs from the previous one, else incremented; a single capture strobe fires in the cycle the counter reaches SETTLE_CYCLES-1; no further strobe until the sample changes.
- On capture:
  - an = 1111: ignored, no state change.
  - an not one-hot-low: set anode_err; no state change.
  - one-hot-low: index = position of the 0 bit (1110→0 … 0111→3); seg decoded against the active-low glyphs 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex). No match: set pattern_err; FSM returns to WAIT_D0.
- Frame FSM, states WAIT_D0 and COLLECT, 2-bit expected index, 16-bit shadow buffer:
  - WAIT_D0: a valid digit 0 is written to shadow[3:0], expected←1, go to COLLECT; other valid digits ignored (no error).
  - COLLECT, index == expected: write shadow nibble; if index==3, copy shadow (including the new nibble) to digits, pulse frame_done, go to WAIT_D0; else expected++.
  - COLLECT, index != expected: set order_err; if index==0, restart (shadow[3:0] written, expected←1, stay COLLECT); else go to WAIT_D0.
- digits changes only with frame_done; partial frames are never visible.
- clear_err and a new error event in the same cycle: the error wins (flag stays 1).

## Timing
- Reset: digits=0, frame_done=0, all error flags=0, FSM=WAIT_D0, expected=0, counter=0, sample register=all-ones (blank).
- Latency: with inputs stable from edge t, the capture strobe fires SETTLE_CYCLES cycles after the sample register first holds the new value; frame_done/digits update on the next edge.
- Patterns held fewer than SETTLE_CYCLES samples are ignored entirely.
- Reset mid-frame discards shadow contents; the next frame must start from digit 0.
- Error flags update on the edge after the capture strobe, same as frame_done.

## Structure
- Package seven_seg_pkg: glyph constants for 0–F, blank/one-hot anode constants, FSM state enum, SEG_W=7, AN_W=4.
- Sub-module seg_glyph_decoder: combinational seg[6:0] → {valid, nibble[3:0]}; reused by the display driver's self-test.

## Test plan
- Scan 1,2,3,4 (an 1110/1101/1011/0111, seg 79/24/30/19), each held 8 cycles → one frame_done, digits=16'h4321, no errors.
- Same scan with each pattern held 3 cycles (SETTLE_CYCLES=4) → no frame_done, digits stays 0.
- 1-cycle glitch seg=7F between digits of a valid frame → ignored; frame_done, digits correct.
- Digit 0 then digit 2 → order_err=1, no frame_done; subsequent clean frame A,b,C,d → digits=16'hdCbA.
- Settled seg=7'h7F on an=1110 → pattern_err=1; an=1100 settled → anode_err=1; clear_err pulse → both 0.
- Reset asserted after digits 0–2 captured, then digits 3,0,1,2,3 → only one frame_done, from the second sequence.
